// File: rtl/instr_decode_stage.sv
// ----------------------------------------------------------------------------
// instr_decode_stage
//
// Registered MIPS instruction decode stage. This stage sits between
// instruction fetch and the register file and control unit. Each accepted
// instruction is split into its fields and classified as R, I or J. The
// 16-bit immediate is extended to WL bits, and the jump target is formed.
// The decoded bundle is held in a main output register (M). A skid
// register (S) is also provided, so that in_ready can be a pure register
// output.
//
// Optional feature macro: DECODE_ILLEGAL_EN
//   defined   : illegal flags unsupported opcodes and R-type funct codes
//   undefined : illegal is tied low and the check logic is absent
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous, active-high reset
//   flush      in   1   synchronous discard of all buffered entries
//   in_valid   in   1   upstream entry present
//   in_ready   out  1   stage can accept an entry this cycle (registered)
//   instr      in   WL  instruction word (fields taken from [31:0])
//   pc_plus4   in   WL  PC+4 of the instruction
//   out_valid  out  1   decoded entry present
//   out_ready  in   1   downstream accepts the entry
//   opcode     out  6   instr[31:26]
//   funct      out  6   instr[5:0]
//   rs/rt/rd   out  5   instr[25:21] / [20:16] / [15:11]
//   shamt      out  5   instr[10:6]
//   imm_ext    out  WL  zero- or sign-extended instr[15:0]
//   jump_addr  out  WL  {pc_plus4[WL-1:28], instr[25:0], 2'b00}
//   itype      out  2   00 = R, 01 = I, 10 = J
//   illegal    out  1   unsupported opcode/funct
//   pc_out     out  WL  pc_plus4 carried with the entry
// ----------------------------------------------------------------------------
module instr_decode_stage #(
    parameter int unsigned WL = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WL-1:0] instr,
    input  logic [WL-1:0] pc_plus4,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [5:0]    opcode,
    output logic [5:0]    funct,
    output logic [4:0]    rs,
    output logic [4:0]    rt,
    output logic [4:0]    rd,
    output logic [4:0]    shamt,
    output logic [WL-1:0] imm_ext,
    output logic [WL-1:0] jump_addr,
    output logic [1:0]    itype,
    output logic          illegal,
    output logic [WL-1:0] pc_out
);

    typedef struct packed {
        logic [5:0]    opcode;
        logic [5:0]    funct;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    rd;
        logic [4:0]    shamt;
        logic [WL-1:0] imm_ext;
        logic [WL-1:0] jump_addr;
        logic [WL-1:0] pc;
        logic [1:0]    itype;
        logic          illegal;
    } entry_t;

    // Bit 0 is the valid bit of M and bit 1 is the valid bit of S.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t state_q, state_d;
    entry_t m_q, m_d;
    entry_t s_q, s_d;
    entry_t dec;

    logic in_xfer;
    logic out_xfer;

    // ------------------------------------------------------------------
    // Combinational field decode of the incoming instruction
    // ------------------------------------------------------------------
    always_comb begin
        dec           = '0;
        dec.opcode    = instr[31:26];
        dec.funct     = instr[5:0];
        dec.rs        = instr[25:21];
        dec.rt        = instr[20:16];
        dec.rd        = instr[15:11];
        dec.shamt     = instr[10:6];
        dec.pc        = pc_plus4;
        dec.jump_addr = {pc_plus4[WL-1:28], instr[25:0], 2'b00};

        unique case (instr[31:26])
            6'h00:        dec.itype = 2'b00;
            6'h02, 6'h03: dec.itype = 2'b10;
            default:      dec.itype = 2'b01;
        endcase

        // The logical immediates (andi/ori/xori/lui) are zero-extended.
        // Every other opcode, including R and J formats, is sign-extended.
        if (instr[31:26] inside {6'h0C, 6'h0D, 6'h0E, 6'h0F})
            dec.imm_ext = {{(WL-16){1'b0}}, instr[15:0]};
        else
            dec.imm_ext = {{(WL-16){instr[15]}}, instr[15:0]};

`ifdef DECODE_ILLEGAL_EN
        unique case (instr[31:26])
            6'h00: begin
                unique case (instr[5:0])
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h08, 6'h09, 6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B:
                        dec.illegal = 1'b0;
                    default:
                        dec.illegal = 1'b1;
                endcase
            end
            6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
            6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21,
            6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B:
                dec.illegal = 1'b0;
            default:
                dec.illegal = 1'b1;
        endcase
`else
        dec.illegal = 1'b0;
`endif
    end

    // ------------------------------------------------------------------
    // Handshake. in_ready depends only on state_q, so there is no
    // combinational path from out_ready to in_ready.
    // ------------------------------------------------------------------
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Next-state and storage update
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;

        // On flush, any input offered in the same cycle is dropped. The
        // data in M is kept, so the outputs hold while out_valid is low.
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        m_d     = dec;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        m_d = dec;
                    end else if (in_xfer) begin
                        s_d     = dec;
                        state_d = ST_FULL;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        m_d     = s_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            m_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs come from M only
    // ------------------------------------------------------------------
    assign opcode    = m_q.opcode;
    assign funct     = m_q.funct;
    assign rs        = m_q.rs;
    assign rt        = m_q.rt;
    assign rd        = m_q.rd;
    assign shamt     = m_q.shamt;
    assign imm_ext   = m_q.imm_ext;
    assign jump_addr = m_q.jump_addr;
    assign itype     = m_q.itype;
    assign illegal   = m_q.illegal;
    assign pc_out    = m_q.pc;

endmodule

// File: tb/tb_instr_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_instr_decode_stage
//
// Directed-vector bench for instr_decode_stage (WL = 32). Inputs are driven
// on the falling edge, and outputs are compared on the falling edge (or
// shortly after an asynchronous reset). Expected values are hand-computed
// constants.
// ----------------------------------------------------------------------------
module tb_instr_decode_stage;

    localparam int unsigned WL = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [WL-1:0] instr;
    logic [WL-1:0] pc_plus4;
    logic          out_valid;
    logic          out_ready;
    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [4:0]    shamt;
    logic [WL-1:0] imm_ext;
    logic [WL-1:0] jump_addr;
    logic [1:0]    itype;
    logic          illegal;
    logic [WL-1:0] pc_out;

    int checks = 0;
    int errors = 0;

`ifdef DECODE_ILLEGAL_EN
    localparam logic ILL_EXP = 1'b1;
`else
    localparam logic ILL_EXP = 1'b0;
`endif

    instr_decode_stage #(.WL(WL)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc_plus4  (pc_plus4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opcode    (opcode),
        .funct     (funct),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .imm_ext   (imm_ext),
        .jump_addr (jump_addr),
        .itype     (itype),
        .illegal   (illegal),
        .pc_out    (pc_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer one entry for a single cycle. Returns at the falling edge after
    // it has been accepted, with in_valid already dropped.
    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        @(negedge clk);
        in_valid = 1'b1;
        instr    = ins;
        pc_plus4 = pc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        instr     = '0;
        pc_plus4  = '0;

        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_itype",     64'(itype),     64'd0);
        check("rst_illegal",   64'(illegal),   64'd0);
        check("rst_imm",       64'(imm_ext),   64'd0);
        check("rst_pc_out",    64'(pc_out),    64'd0);

        @(negedge clk);
        rst = 1'b0;

        // add $8,$9,$10
        send(32'h012A4020, 32'h0040_0004);
        check("add_valid",   64'(out_valid), 64'd1);
        check("add_opcode",  64'(opcode),    64'h00);
        check("add_rs",      64'(rs),        64'd9);
        check("add_rt",      64'(rt),        64'd10);
        check("add_rd",      64'(rd),        64'd8);
        check("add_shamt",   64'(shamt),     64'd0);
        check("add_funct",   64'(funct),     64'h20);
        check("add_itype",   64'(itype),     64'd0);
        check("add_illegal", 64'(illegal),   64'd0);

        // addi: sign extension
        send(32'h2008FFFF, 32'h0040_0008);
        check("addi_imm",   64'(imm_ext), 64'hFFFF_FFFF);
        check("addi_itype", 64'(itype),   64'd1);

        // ori: zero extension
        send(32'h3508FFFF, 32'h0040_000C);
        check("ori_imm",   64'(imm_ext), 64'h0000_FFFF);
        check("ori_itype", 64'(itype),   64'd1);

        // lui: zero extension with bit 15 set
        send(32'h3C088000, 32'h0040_0010);
        check("lui_imm", 64'(imm_ext), 64'h0000_8000);

        // beq: negative branch offset
        send(32'h1000FFFE, 32'h0040_0014);
        check("beq_imm", 64'(imm_ext), 64'hFFFF_FFFE);

        // j
        send(32'h08000010, 32'h4000_0004);
        check("j_jump",  64'(jump_addr), 64'h4000_0040);
        check("j_itype", 64'(itype),     64'd2);
        check("j_pc",    64'(pc_out),    64'h4000_0004);

        // Entry drains and the data outputs hold their last values
        @(negedge clk);
        check("hold_valid",  64'(out_valid), 64'd0);
        check("hold_opcode", 64'(opcode),    64'h02);
        check("hold_jump",   64'(jump_addr), 64'h4000_0040);

        // Back-to-back at full throughput
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr    = 32'h012A4020;
            pc_plus4 = 32'h0000_0300 + 32'(i * 4);
            @(negedge clk);
            check("tput_valid", 64'(out_valid), 64'd1);
            check("tput_ready", 64'(in_ready),  64'd1);
            check("tput_pc",    64'(pc_out),    64'h300 + 64'(i * 4));
        end
        in_valid = 1'b0;
        @(negedge clk);

        // Backpressure: offer A, B, C with out_ready low
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h012A4020;
        pc_plus4  = 32'h0000_0100;
        @(negedge clk);
        check("bp_ready_one", 64'(in_ready), 64'd1);
        pc_plus4 = 32'h0000_0104;
        @(negedge clk);
        check("bp_ready_full", 64'(in_ready), 64'd0);
        check("bp_pc_a",       64'(pc_out),   64'h100);
        pc_plus4 = 32'h0000_0108;
        @(negedge clk);
        check("bp_stall_ready", 64'(in_ready),  64'd0);
        check("bp_stall_valid", 64'(out_valid), 64'd1);
        check("bp_stall_pc",    64'(pc_out),    64'h100);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_pc_b",      64'(pc_out),   64'h104);
        check("bp_ready_rel", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_pc_c",    64'(pc_out),    64'h108);
        check("bp_valid_c", 64'(out_valid), 64'd1);
        @(negedge clk);
        check("bp_drained", 64'(out_valid), 64'd0);

        // Flush while FULL with in_valid high
        out_ready = 1'b0;
        in_valid  = 1'b1;
        pc_plus4  = 32'h0000_0200;
        @(negedge clk);
        pc_plus4 = 32'h0000_0204;
        @(negedge clk);
        check("fl_full", 64'(in_ready), 64'd0);
        pc_plus4 = 32'h0000_0208;
        flush    = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ready", 64'(in_ready),  64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("fl_nothing", 64'(out_valid), 64'd0);

        // Flush with a real input transfer in the same cycle: input is dropped
        in_valid = 1'b1;
        pc_plus4 = 32'h0000_020C;
        flush    = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_in_dropped", 64'(out_valid), 64'd0);

        // Reset mid-stream
        out_ready = 1'b0;
        send(32'h2008FFFF, 32'h0000_0400);
        check("rs_valid_pre", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rs_valid", 64'(out_valid), 64'd0);
        check("rs_imm",   64'(imm_ext),   64'd0);
        check("rs_pc",    64'(pc_out),    64'd0);
        check("rs_ready", 64'(in_ready),  64'd1);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rs_after_ready", 64'(in_ready),  64'd1);
        check("rs_after_valid", 64'(out_valid), 64'd0);

        // Illegal detection
        send(32'hFC000000, 32'h0000_0500);
        check("ill_opcode",   64'(illegal), 64'(ILL_EXP));
        check("ill_op_itype", 64'(itype),   64'd1);
        send(32'h0000003F, 32'h0000_0504);
        check("ill_funct", 64'(illegal), 64'(ILL_EXP));
        send(32'h012A4020, 32'h0000_0508);
        check("ill_add", 64'(illegal), 64'd0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
